jpeg_pixel_capture: RTL and testbench

- Synthesizable successor to the bench-side pixel capture that sits behind the JPEG decoder.
- Takes the decoder's pixel stream (OutEnable, X/Y, RGB, frame dimensions) in MCU order.
- Computes the frame-buffer address and converts each pixel to the selected format.
- Buffers the resulting word writes in a FIFO and issues them to memory over a valid/ready port. Tracks frame completion and error conditions.

---
 rtl/jpeg_capture_pkg.sv | 32 +++
 rtl/jpeg_pixel_capture_if.sv | 13 +
 rtl/jpeg_capture_fifo.sv | 44 ++++
 rtl/jpeg_pixel_capture.sv | 178 +++++++++++++++++
 tb/tb_jpeg_pixel_capture.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jpeg_capture_pkg.sv
// Shared constants, frame states and pixel helpers for the JPEG pixel capture block.
package jpeg_capture_pkg;

    localparam logic FMT_RGB888 = 1'b0;
    localparam logic FMT_RGB565 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } frame_state_t;

    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    function automatic logic [15:0] pack_rgb565(input logic [7:0] r, input logic [7:0] g,
                                                input logic [7:0] b);
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

    // Non-reflected CRC-32 step over one pixel, consuming {R,G,B} MSB first.
    function automatic logic [31:0] crc32_rgb(input logic [31:0] crc, input logic [23:0] rgb);
        logic [31:0] c;
        c = crc;
        for (int i = 23; i >= 0; i--) begin
            if (c[31] ^ rgb[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
            else                c = {c[30:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/jpeg_pixel_capture_if.sv
// Memory write port of the pixel capture: valid/ready word writes with byte enables.
interface jpeg_pixel_capture_if #(
    parameter int ADDR_W = 24
);
    logic              MemValid;
    logic              MemReady;
    logic [ADDR_W-1:0] MemAddr;
    logic [31:0]       MemData;
    logic [3:0]        MemStrb;

    modport master (output MemValid, MemAddr, MemData, MemStrb, input MemReady);
    modport slave  (input MemValid, MemAddr, MemData, MemStrb, output MemReady);
endinterface

// File: rtl/jpeg_capture_fifo.sv
// Synchronous first-word fall-through FIFO; a push on a full FIFO succeeds when a pop happens in the same cycle.
module jpeg_capture_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = store[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/jpeg_pixel_capture.sv
// Captures the decoder pixel stream, formats each pixel into a frame-buffer word write and queues it to memory.
// Optional macro JPEG_CAPTURE_CRC_EN adds a running per-frame CRC-32 on FrameCrc.
module jpeg_pixel_capture
    import jpeg_capture_pkg::*;
#(
    parameter int ADDR_W     = 24,
    parameter int FIFO_DEPTH = 16,
    parameter int DIM_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 FrameStart,
    input  logic                 Format,
    input  logic [ADDR_W-1:0]    BaseAddr,
    input  logic                 PixEnable,
    input  logic [DIM_W-1:0]     PixWidth,
    input  logic [DIM_W-1:0]     PixHeight,
    input  logic [DIM_W-1:0]     PixX,
    input  logic [DIM_W-1:0]     PixY,
    input  logic [7:0]           PixR,
    input  logic [7:0]           PixG,
    input  logic [7:0]           PixB,
    jpeg_pixel_capture_if.master mem,
    output logic                 Busy,
    output logic                 FrameDone,
    output logic                 Overflow,
    output logic                 RangeErr,
    output logic [2*DIM_W-1:0]   PixCount,
    output logic [31:0]          FrameCrc
);
    localparam int IW = 2 * DIM_W;
    localparam int EW = ADDR_W + 36;

    logic              fmt_q;
    logic [ADDR_W-1:0] base_q;
    logic              in_range;
    logic              s1_valid, s2_valid;
    logic [DIM_W-1:0]  s1_x, s1_y, s1_w;
    logic [23:0]       s1_rgb, s2_rgb;
    logic [IW-1:0]     s2_idx;
    logic [ADDR_W-1:0] s3_addr;
    logic [31:0]       s3_data;
    logic [3:0]        s3_strb;
    logic              push, pop, push_ok;
    logic              fifo_full, fifo_empty;
    logic [EW-1:0]     fifo_rdata;
    logic [IW-1:0]     frame_total;
    frame_state_t      state_q, state_d;
    logic              done_d;

    assign in_range = (PixX < PixWidth) && (PixY < PixHeight);

    always_ff @(posedge clk) begin
        if (rst) begin
            fmt_q  <= FMT_RGB888;
            base_q <= '0;
        end else if (FrameStart) begin
            fmt_q  <= Format;
            base_q <= BaseAddr;
        end
    end

    // FrameStart flushes stage 2 but the same-cycle pixel still enters stage 1 for the new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= PixEnable && in_range;
            s2_valid <= s1_valid && !FrameStart;
        end
    end

    always_ff @(posedge clk) begin
        s1_x   <= PixX;
        s1_y   <= PixY;
        s1_w   <= PixWidth;
        s1_rgb <= {PixR, PixG, PixB};
        s2_idx <= IW'(s1_w) * IW'(s1_y) + IW'(s1_x);
        s2_rgb <= s1_rgb;
    end

    always_comb begin
        s3_addr = base_q + ADDR_W'(s2_idx);
        s3_data = {8'h00, s2_rgb};
        s3_strb = 4'hF;
        if (fmt_q == FMT_RGB565) begin
            s3_addr = base_q + ADDR_W'(s2_idx >> 1);
            s3_data = {2{pack_rgb565(s2_rgb[23:16], s2_rgb[15:8], s2_rgb[7:0])}};
            s3_strb = s2_idx[0] ? 4'b1100 : 4'b0011;
        end
    end

    assign push    = s2_valid && !FrameStart;
    assign pop     = !fifo_empty && mem.MemReady;
    assign push_ok = push && (!fifo_full || pop);

    jpeg_capture_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({s3_addr, s3_data, s3_strb}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign mem.MemValid = !fifo_empty;
    assign mem.MemAddr  = fifo_empty ? '0 : fifo_rdata[EW-1 -: ADDR_W];
    assign mem.MemData  = fifo_empty ? '0 : fifo_rdata[35:4];
    assign mem.MemStrb  = fifo_empty ? '0 : fifo_rdata[3:0];
    assign Busy         = s1_valid || s2_valid || !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            PixCount <= '0;
            Overflow <= 1'b0;
            RangeErr <= 1'b0;
        end else if (FrameStart) begin
            PixCount <= '0;
            Overflow <= 1'b0;
            RangeErr <= PixEnable && !in_range;
        end else begin
            if (push_ok)               PixCount <= PixCount + IW'(1);
            if (push && !push_ok)      Overflow <= 1'b1;
            if (PixEnable && !in_range) RangeErr <= 1'b1;
        end
    end

    assign frame_total = IW'(PixWidth) * IW'(PixHeight);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            FrameDone <= 1'b0;
        end else begin
            state_q   <= state_d;
            FrameDone <= done_d;
        end
    end

    // FrameStart overrides everything, so an abandoned drain never reports completion.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE:   state_d = ST_IDLE;
            ST_ACTIVE: if (PixCount == frame_total) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (!Busy) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
        if (FrameStart) begin
            state_d = ST_ACTIVE;
            done_d  = 1'b0;
        end
    end

`ifdef JPEG_CAPTURE_CRC_EN
    logic [31:0] crc_q;

    always_ff @(posedge clk) begin
        if (rst)             crc_q <= '0;
        else if (FrameStart) crc_q <= CRC_INIT;
        else if (push_ok)    crc_q <= crc32_rgb(crc_q, s2_rgb);
    end

    assign FrameCrc = crc_q;
`else
    assign FrameCrc = '0;
`endif

endmodule

// File: tb/tb_jpeg_pixel_capture.sv
// Randomized and directed bench for jpeg_pixel_capture against a queue-based behavioural model.
module tb_jpeg_pixel_capture;
    localparam int ADDR_W = 24;
    localparam int DEPTH  = 16;

    typedef struct {
        logic [23:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [23:0] rgb;
    } wr_t;

    logic        clk = 1'b0, rst = 1'b1, FrameStart = 1'b0, Format = 1'b0, PixEnable = 1'b0;
    logic [23:0] BaseAddr = '0;
    logic [15:0] PixWidth = '0, PixHeight = '0, PixX = '0, PixY = '0;
    logic [7:0]  PixR = '0, PixG = '0, PixB = '0;
    logic        Busy, FrameDone, Overflow, RangeErr;
    logic [31:0] PixCount, FrameCrc;

    jpeg_pixel_capture_if #(.ADDR_W(ADDR_W)) bus ();

    jpeg_pixel_capture #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .DIM_W(16)) dut (
        .clk(clk), .rst(rst), .FrameStart(FrameStart), .Format(Format), .BaseAddr(BaseAddr),
        .PixEnable(PixEnable), .PixWidth(PixWidth), .PixHeight(PixHeight), .PixX(PixX), .PixY(PixY),
        .PixR(PixR), .PixG(PixG), .PixB(PixB), .mem(bus), .Busy(Busy), .FrameDone(FrameDone),
        .Overflow(Overflow), .RangeErr(RangeErr), .PixCount(PixCount), .FrameCrc(FrameCrc)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_fail = 0, done_seen = 0;
    bit          rand_ready = 1'b0;
    wr_t         m_q[$], wlog[$], m_p1, m_p2;
    bit          m_p1_v = 1'b0, m_p2_v = 1'b0, m_ovf = 1'b0, m_rerr = 1'b0, m_done = 1'b0;
    logic        m_fmt = 1'b0;
    logic [23:0] m_base = '0;
    logic [31:0] m_cnt = '0, m_crc = '0;
    int          m_state = 0;  // 0 idle, 1 active, 2 drain

    function automatic logic [31:0] crc_ref(input logic [31:0] c_in, input logic [23:0] d);
        logic [31:0] c;
        logic        msb;
        c = c_in;
        for (int i = 23; i >= 0; i--) begin
            msb = c[31];
            c   = {c[30:0], 1'b0};
            if (msb ^ d[i]) c = c ^ 32'h04C11DB7;
        end
        return c;
    endfunction

    function automatic wr_t make_entry(input logic fmt, input logic [23:0] base, input logic [15:0] w,
                                       input logic [15:0] x, input logic [15:0] y,
                                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        wr_t         e;
        logic [31:0] idx;
        logic [15:0] p;
        idx   = 32'(w) * 32'(y) + 32'(x);
        e.rgb = {r, g, b};
        if (!fmt) begin
            e.addr = base + idx[23:0];
            e.data = {8'h00, r, g, b};
            e.strb = 4'hF;
        end else begin
            p      = {r[7:3], g[7:2], b[7:3]};
            e.addr = base + idx[24:1];
            e.data = {p, p};
            e.strb = idx[0] ? 4'b1100 : 4'b0011;
        end
        return e;
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model across the coming clock edge using the inputs now applied.
    task automatic model_step();
        bit          busy, pop, push, push_ok, inr;
        logic        fmt_eff;
        logic [23:0] base_eff;
        if (rst) begin
            m_q.delete();
            m_p1_v = 0; m_p2_v = 0; m_fmt = 0; m_base = '0; m_cnt = '0; m_crc = '0;
            m_ovf = 0; m_rerr = 0; m_done = 0; m_state = 0;
            return;
        end
        if (bus.MemValid === 1'b1 && bus.MemReady === 1'b1)
            wlog.push_back('{bus.MemAddr, bus.MemData, bus.MemStrb, 24'h0});
        busy    = m_p1_v || m_p2_v || (m_q.size() != 0);
        pop     = (m_q.size() != 0) && bus.MemReady;
        push    = m_p2_v && !FrameStart;
        push_ok = push && (m_q.size() < DEPTH || pop);
        inr     = (PixX < PixWidth) && (PixY < PixHeight);
        m_done  = (m_state == 2) && !busy && !FrameStart;
        if (FrameStart) m_state = 1;
        else if (m_state == 1 && m_cnt == 32'(PixWidth) * 32'(PixHeight)) m_state = 2;
        else if (m_state == 2 && !busy) m_state = 0;
        if (FrameStart) begin
            m_cnt = '0; m_ovf = 0; m_rerr = 0; m_crc = 32'hFFFFFFFF;
        end else if (push_ok) begin
            m_cnt = m_cnt + 1;
            m_crc = crc_ref(m_crc, m_p2.rgb);
        end else if (push) begin
            m_ovf = 1;
        end
        if (PixEnable && !inr) m_rerr = 1;
        if (pop) void'(m_q.pop_front());
        if (push_ok) m_q.push_back(m_p2);
        fmt_eff  = FrameStart ? Format : m_fmt;
        base_eff = FrameStart ? BaseAddr : m_base;
        m_p2_v   = m_p1_v && !FrameStart;
        m_p2     = m_p1;
        m_p1_v   = PixEnable && inr;
        m_p1     = make_entry(fmt_eff, base_eff, PixWidth, PixX, PixY, PixR, PixG, PixB);
        if (FrameStart) begin
            m_fmt  = Format;
            m_base = BaseAddr;
        end
    endtask

    task automatic check_output();
        logic [31:0] exp_crc;
`ifdef JPEG_CAPTURE_CRC_EN
        exp_crc = m_crc;
`else
        exp_crc = '0;
`endif
        cmp("MemValid", bus.MemValid, m_q.size() != 0);
        if (m_q.size() != 0) begin
            cmp("MemAddr", bus.MemAddr, m_q[0].addr);
            cmp("MemData", bus.MemData, m_q[0].data);
            cmp("MemStrb", bus.MemStrb, m_q[0].strb);
        end
        cmp("Busy", Busy, m_p1_v || m_p2_v || (m_q.size() != 0));
        cmp("FrameDone", FrameDone, m_done);
        cmp("PixCount", PixCount, m_cnt);
        cmp("Overflow", Overflow, m_ovf);
        cmp("RangeErr", RangeErr, m_rerr);
        cmp("FrameCrc", FrameCrc, exp_crc);
        if (FrameDone === 1'b1) done_seen++;
    endtask

    task automatic tick();
        if (rand_ready) bus.MemReady = ($urandom_range(0, 9) < 7);
        model_step();
        @(negedge clk);
        check_output();
    endtask

    task automatic apply_stimulus(input logic [15:0] x, input logic [15:0] y,
                                  input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        PixEnable = 1'b1; PixX = x; PixY = y; PixR = r; PixG = g; PixB = b;
        tick();
        PixEnable = 1'b0;
    endtask

    task automatic start_frame(input logic fmt, input logic [23:0] base, input logic [15:0] w,
                               input logic [15:0] h);
        FrameStart = 1'b1; Format = fmt; BaseAddr = base; PixWidth = w; PixHeight = h;
        tick();
        FrameStart = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int start;
        start = done_seen;
        for (int i = 0; i < budget && done_seen == start; i++) tick();
        cmp(name, 64'(done_seen - start), 1);
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget && Busy !== 1'b0; i++) tick();
        cmp(name, Busy, 0);
    endtask

    initial begin
        int w, h;
        bit fmt;
        logic [23:0] base;
        bus.MemReady = 1'b0;
        @(negedge clk);
        tick(); tick();
        cmp("reset_MemValid", bus.MemValid, 0);
        cmp("reset_MemAddr", bus.MemAddr, 0);
        cmp("reset_PixCount", PixCount, 0);
        cmp("reset_FrameDone", FrameDone, 0);
        rst = 1'b0;
        tick();

        // RGB888 4x2 frame in raster order with memory always ready
        bus.MemReady = 1'b1; wlog.delete();
        start_frame(1'b0, 24'h100, 16'd4, 16'd2);
        for (int i = 0; i < 8; i++)
            apply_stimulus(16'(i % 4), 16'(i / 4), 8'(16 * i + 1), 8'(32 + i), 8'(64 + i));
        wait_done("t1_done", 20);
        cmp("t1_writes", 64'(wlog.size()), 8);
        cmp("t1_PixCount", PixCount, 8);
        for (int i = 0; i < wlog.size(); i++) begin
            cmp("t1_addr", wlog[i].addr, 64'(24'h100 + i));
            cmp("t1_data", wlog[i].data, {8'h00, 8'(16 * i + 1), 8'(32 + i), 8'(64 + i)});
        end

        // RGB565 pair sharing one word
        wlog.delete();
        start_frame(1'b1, 24'h0, 16'd2, 16'd1);
        apply_stimulus(16'd0, 16'd0, 8'h12, 8'h34, 8'h56);
        apply_stimulus(16'd1, 16'd0, 8'hFF, 8'h00, 8'hFF);
        wait_done("t2_done", 20);
        cmp("t2_writes", 64'(wlog.size()), 2);
        cmp("t2_addr0", wlog[0].addr, 0);
        cmp("t2_data0", wlog[0].data, 32'h11AA11AA);
        cmp("t2_strb0", wlog[0].strb, 4'b0011);
        cmp("t2_addr1", wlog[1].addr, 0);
        cmp("t2_data1", wlog[1].data, 32'hF81FF81F);
        cmp("t2_strb1", wlog[1].strb, 4'b1100);

        // 20 pixels into a stalled memory port
        wlog.delete(); bus.MemReady = 1'b0;
        start_frame(1'b0, 24'h200, 16'd8, 16'd4);
        for (int i = 0; i < 20; i++) apply_stimulus(16'(i % 8), 16'(i / 8), 8'(i), 8'(i), 8'(i));
        repeat (3) tick();
        cmp("t3_PixCount", PixCount, 16);
        cmp("t3_Overflow", Overflow, 1);
        cmp("t3_MemValid", bus.MemValid, 1);
        repeat (4) tick();
        cmp("t3_held_addr", bus.MemAddr, 24'h200);
        bus.MemReady = 1'b1;
        wait_idle("t3_drain", 40);
        cmp("t3_writes", 64'(wlog.size()), 16);
        cmp("t3_last_addr", wlog[15].addr, 24'h20F);

        // Out-of-range column
        wlog.delete();
        start_frame(1'b0, 24'h0, 16'd4, 16'd1);
        apply_stimulus(16'd4, 16'd0, 8'hAA, 8'hBB, 8'hCC);
        repeat (3) tick();
        cmp("t4_RangeErr", RangeErr, 1);
        cmp("t4_PixCount", PixCount, 0);
        cmp("t4_writes", 64'(wlog.size()), 0);
        for (int i = 0; i < 4; i++) apply_stimulus(16'(i), 16'd0, 8'(i), 8'h11, 8'h22);
        wait_done("t4_done", 20);
        cmp("t4_PixCount_end", PixCount, 4);

        // FrameStart during DRAIN with entries still queued
        wlog.delete(); bus.MemReady = 1'b0;
        start_frame(1'b0, 24'h300, 16'd2, 16'd2);
        for (int i = 0; i < 4; i++) apply_stimulus(16'(i % 2), 16'(i / 2), 8'h01, 8'h02, 8'(i));
        repeat (6) tick();
        done_seen = 0;
        start_frame(1'b0, 24'h400, 16'd2, 16'd2);
        cmp("t5_PixCount", PixCount, 0);
        cmp("t5_old_addr", bus.MemAddr, 24'h300);
        bus.MemReady = 1'b1;
        repeat (10) tick();
        cmp("t5_old_writes", 64'(wlog.size()), 4);
        cmp("t5_no_done", 64'(done_seen), 0);
        for (int i = 0; i < 4; i++) apply_stimulus(16'(i % 2), 16'(i / 2), 8'h05, 8'h06, 8'(i));
        wait_done("t5_new_done", 20);
        cmp("t5_new_addr", wlog[4].addr, 24'h400);

        // Zero-area frame completes without pixels
        start_frame(1'b0, 24'h0, 16'd0, 16'd3);
        wait_done("t6_done", 10);

        // Single black pixel for the CRC
        start_frame(1'b0, 24'h500, 16'd1, 16'd1);
        apply_stimulus(16'd0, 16'd0, 8'h00, 8'h00, 8'h00);
        wait_done("t7_done", 20);
`ifdef JPEG_CAPTURE_CRC_EN
        cmp("t7_FrameCrc", FrameCrc, crc_ref(32'hFFFFFFFF, 24'h000000));
`else
        cmp("t7_FrameCrc", FrameCrc, 0);
`endif

        // Random frames with random memory back-pressure
        rand_ready = 1'b1;
        for (int f = 0; f < 10; f++) begin
            w = $urandom_range(1, 4); h = $urandom_range(1, 4);
            fmt = 1'($urandom_range(0, 1)); base = 24'($urandom);
            for (int i = 0; i < w * h; i++) begin
                if (i == 0 && $urandom_range(0, 1) == 1) begin
                    FrameStart = 1'b1; Format = fmt; BaseAddr = base;
                    PixWidth = 16'(w); PixHeight = 16'(h);
                    apply_stimulus(16'd0, 16'd0, 8'($urandom), 8'($urandom), 8'($urandom));
                    FrameStart = 1'b0;
                    continue;
                end
                if (i == 0) start_frame(fmt, base, 16'(w), 16'(h));
                while ($urandom_range(0, 3) == 0) tick();
                if ($urandom_range(0, 7) == 0)
                    apply_stimulus(16'(w), 16'($urandom_range(0, h - 1)), 8'h0F, 8'hF0, 8'h3C);
                apply_stimulus(16'(i % w), 16'(i / w), 8'($urandom), 8'($urandom), 8'($urandom));
            end
            wait_done("rand_done", 200);
            cmp("rand_PixCount", PixCount, 32'(w * h));
        end

        // Reset in the middle of a frame
        start_frame(1'b0, 24'h600, 16'd4, 16'd4);
        for (int i = 0; i < 3; i++) apply_stimulus(16'(i), 16'd0, 8'h77, 8'h88, 8'h99);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rand_ready = 1'b0;
        cmp("midrst_MemValid", bus.MemValid, 0);
        cmp("midrst_PixCount", PixCount, 0);
        cmp("midrst_Busy", Busy, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
